serial_in_receiver: RTL

//  Serial input front-end for the SAP-2 input port. Deserialises an asynchronous 8N1 serial

---
 rtl/serial_in_receiver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_in_receiver.sv
// serial_in_receiver: 8N1 serial deserialiser feeding the SAP-2 input port.
// A byte is held on oData with oReady until the CPU read strobe (iAck)
// consumes it; framing and overrun errors are sticky until the next ack.
module serial_in_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iRx,
    input  logic       iAck,
    output logic [7:0] oData,
    output logic       oReady,
    output logic       oFrameErr,
    output logic       oOverrun,
    output logic       oBusy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;
    logic                   rxs;

    // Synchroniser shift: new iRx enters at bit 0, the oldest stage is rxs.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], iRx};
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Next-state logic: ack is applied first so a completing frame sees the cleared flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = ready_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (iAck) begin
            ready_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        // Glitch shorter than half a bit: not a real start bit.
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                        cnt_d   = FULL_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (rxs) begin
                        if (!ready_d) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                        end else begin
                            // Previous byte still unread: keep it, drop the new one.
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Busy is a registered decode of the upcoming state so it tracks state_q exactly.
    always_comb begin
        busy_d = (state_d != IDLE);
    end

    // All state, synchroniser and output registers, with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign oData     = data_q;
    assign oReady    = ready_q;
    assign oFrameErr = ferr_q;
    assign oOverrun  = ovr_q;
    assign oBusy     = busy_q;

endmodule
